// File: rtl/sram_pkg.sv
// Shared types and constants for the latency-modelled SRAM slice.
// FSM states, LFSR seed/taps, default parameter values and counter width.
package sram_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3 of a left-shifting register
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DEPTH_W = 12;
   localparam int unsigned DEF_LATENCY = 1;

   // Holds LATENCY-1 (max 14) plus up to 7 random extra cycles
   localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/sram_lfsr.sv
// 8-bit Fibonacci LFSR supplying 0..7 extra wait cycles to sram_lat.
// Only instantiated when SRAM_RAND_DELAY_EN is defined.
module sram_lfsr
   import sram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] extra
);

   logic [7:0] lfsr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   assign extra = lfsr_q[2:0];

endmodule

// File: rtl/sram_lat.sv
// Single-outstanding SRAM with configurable access latency and byte masks.
// Define SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven extra wait cycles per request.
module sram_lat
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DEPTH_W = DEF_DEPTH_W,
   parameter int unsigned LATENCY = DEF_LATENCY
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wmask,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_write,
   output logic                rsp_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_HI = OFF_W + DEPTH_W;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     load_cnt;
   logic                 accept;
   logic                 enter_resp;

   logic                 wr_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [STRB_W-1:0]    wmask_q;

   logic                 cur_write;
   logic [ADDR_W-1:0]    cur_addr;
   logic [DATA_W-1:0]    cur_wdata;
   logic [STRB_W-1:0]    cur_wmask;
   logic                 oor;
   logic [DEPTH_W-1:0]   idx;

   logic [DATA_W-1:0]    mem [0:(1 << DEPTH_W) - 1];
   logic [DATA_W-1:0]    rd_q;
   logic                 rd_valid_q;

`ifdef SRAM_RAND_DELAY_EN
   logic [2:0] extra;

   sram_lfsr u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .extra (extra)
   );

   assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(extra);
`else
   assign load_cnt = CNT_W'(LATENCY - 1);
`endif

   assign req_ready = rst & ((state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready));
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state_q == S_RESP);

   // A zero-wait request is served on its own accept edge, so the access must
   // see the live request fields rather than the not-yet-latched copies.
   assign cur_write = accept ? req_write : wr_q;
   assign cur_addr  = accept ? req_addr  : addr_q;
   assign cur_wdata = accept ? req_wdata : wdata_q;
   assign cur_wmask = accept ? req_wmask : wmask_q;

   assign oor = (cur_addr >> IDX_HI) != '0;
   assign idx = cur_addr[IDX_HI-1:OFF_W];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      unique case (state_q)
         S_IDLE, S_RESP: begin
            if (accept) begin
               if (load_cnt == '0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = load_cnt;
               end
            end else if (state_q == S_RESP && rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // Leave on the edge that takes the count to zero: LATENCY edges total
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rsp_write  <= 1'b0;
         rsp_err    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
         end
         if (enter_resp) begin
            rsp_write  <= cur_write;
            rsp_err    <= oor;
            rd_valid_q <= ~cur_write & ~oor;
         end
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset
   always_ff @(posedge clk) begin
      if (enter_resp && !oor) begin
         if (cur_write) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (cur_wmask[b]) begin
                  mem[idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
               end
            end
         end else begin
            rd_q <= mem[idx];
         end
      end
   end

   assign rsp_rdata = rd_valid_q ? rd_q : '0;

endmodule

// File: tb/tb_sram_lat.sv
// Directed self-checking bench for sram_lat at LATENCY 1, 4 and 8.
// With SRAM_RAND_DELAY_EN defined, latencies are range-checked and a random-delay replay test runs.
module tb_sram_lat;

`ifdef SRAM_RAND_DELAY_EN
   localparam int EXTRA = 7;
`else
   localparam int EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_write [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_wmask [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_write [3];
   logic        rsp_err   [3];

   int checks = 0;
   int errors = 0;
   int lat_seq [2][64];

   always #5 clk = ~clk;

   sram_lat u_lat1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_write(rsp_write[0]), .rsp_err(rsp_err[0])
   );

   sram_lat #(.LATENCY(4)) u_lat4 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_write(rsp_write[1]), .rsp_err(rsp_err[1])
   );

   sram_lat #(.LATENCY(8)) u_lat8 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_write(rsp_write[2]), .rsp_err(rsp_err[2])
   );

   // Issue one request and return the number of cycles until rsp_valid is seen
   task automatic send(input int u, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, output int lat);
      int n;
      @(negedge clk);
      req_valid[u] = 1'b1;
      req_write[u] = w;
      req_addr[u]  = a;
      req_wdata[u] = d;
      req_wmask[u] = m;
      rsp_ready[u] = 1'b0;
      n = 0;
      while (!req_ready[u] && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 req_valid[u] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid[u] && lat < 40);
      checks++;
      if (!rsp_valid[u]) begin
         errors++;
         $display("FAIL send_timeout: unit %0d rsp_valid=%b after %0d cycles, required 1", u, rsp_valid[u], lat);
      end
   endtask

   task automatic release_rsp(input int u);
      rsp_ready[u] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[u] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_wmask[i] = '0;
         rsp_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid[0]); end
      checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b required 0", req_ready[0]); end
      checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", rsp_rdata[0]); end
      checks++; if (rsp_write[0] !== 1'b0) begin errors++; $display("FAIL rst_write: got %b required 0", rsp_write[0]); end
      checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", rsp_err[0]); end
      rst = 1'b1;
      #1;
      checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_release_ready0: got %b required 1", req_ready[0]); end
      checks++; if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL rst_release_ready2: got %b required 1", req_ready[2]); end
   endtask

   task automatic test_back_to_back();
      int lat;
      send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
      checks++; if (lat < 1 || lat > 1 + EXTRA) begin errors++; $display("FAIL b2b_wr_latency: got %0d required 1..%0d", lat, 1 + EXTRA); end
      checks++; if (rsp_write[0] !== 1'b1) begin errors++; $display("FAIL b2b_wr_echo: got %b required 1", rsp_write[0]); end
      checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL b2b_wr_rdata: got %h required 0", rsp_rdata[0]); end
      checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL b2b_wr_err: got %b required 0", rsp_err[0]); end
      rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[0]  = 32'h10;
      #1;
      checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", req_ready[0]); end
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid[0] && lat < 40);
      checks++; if (lat < 1 || lat > 1 + EXTRA || !rsp_valid[0]) begin errors++; $display("FAIL b2b_rd_latency: got %0d valid=%b required 1..%0d", lat, rsp_valid[0], 1 + EXTRA); end
      checks++; if (rsp_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd_data: got %h required deadbeef", rsp_rdata[0]); end
      checks++; if (rsp_write[0] !== 1'b0) begin errors++; $display("FAIL b2b_rd_echo: got %b required 0", rsp_write[0]); end
      checks++; if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL b2b_rd_err: got %b required 0", rsp_err[0]); end
      release_rsp(0);
   endtask

   task automatic test_partial_mask();
      int lat;
      send(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat);
      release_rsp(0);
      send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat);
      release_rsp(0);
      send(0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'b0000, lat);
      checks++; if (rsp_err[0] !== 1'b0 || rsp_write[0] !== 1'b1) begin errors++; $display("FAIL mask0_rsp: got err=%b write=%b required err=0 write=1", rsp_err[0], rsp_write[0]); end
      release_rsp(0);
      send(0, 1'b0, 32'h20, '0, '0, lat);
      checks++; if (rsp_rdata[0] !== 32'h11BB33DD) begin errors++; $display("FAIL partial_mask: got %h required 11bb33dd", rsp_rdata[0]); end
      release_rsp(0);
   endtask

   task automatic test_latency_backpressure();
      int lat;
      send(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat);
      checks++; if (lat < 4 || lat > 4 + EXTRA) begin errors++; $display("FAIL lat4_wr_latency: got %0d required 4..%0d", lat, 4 + EXTRA); end
      release_rsp(1);
      send(1, 1'b0, 32'h30, '0, '0, lat);
      checks++; if (lat < 4 || lat > 4 + EXTRA) begin errors++; $display("FAIL lat4_rd_latency: got %0d required 4..%0d", lat, 4 + EXTRA); end
      checks++; if (rsp_rdata[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL lat4_rd_data: got %h required cafef00d", rsp_rdata[1]); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, rsp_valid[1]); end
         checks++; if (rsp_rdata[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_data[%0d]: got %h required cafef00d", i, rsp_rdata[1]); end
         checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b required 0", i, req_ready[1]); end
      end
      rsp_ready[1] = 1'b1;
      #1;
      checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", req_ready[1]); end
      @(posedge clk);
      #1 rsp_ready[1] = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_idle_valid: got %b required 0", rsp_valid[1]); end
   endtask

   task automatic test_out_of_range();
      int lat;
      send(0, 1'b1, 32'h0, 32'h01234567, 4'hF, lat);
      release_rsp(0);
      send(0, 1'b1, 32'h0000_4000, 32'hFFFFFFFF, 4'hF, lat);
      checks++; if (rsp_err[0] !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b required 1", rsp_err[0]); end
      checks++; if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL oor_wr_rdata: got %h required 0", rsp_rdata[0]); end
      release_rsp(0);
      send(0, 1'b0, 32'h0000_4000, '0, '0, lat);
      checks++; if (rsp_err[0] !== 1'b1 || rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL oor_rd: got err=%b data=%h required err=1 data=0", rsp_err[0], rsp_rdata[0]); end
      release_rsp(0);
      send(0, 1'b0, 32'h0, '0, '0, lat);
      checks++; if (rsp_rdata[0] !== 32'h01234567 || rsp_err[0] !== 1'b0) begin errors++; $display("FAIL oor_alias_rd: got err=%b data=%h required err=0 data=01234567", rsp_err[0], rsp_rdata[0]); end
      release_rsp(0);
   endtask

   task automatic test_reset_mid();
      int lat;
      send(2, 1'b1, 32'h40, 32'h12345678, 4'hF, lat);
      checks++; if (lat < 8 || lat > 8 + EXTRA) begin errors++; $display("FAIL lat8_latency: got %0d required 8..%0d", lat, 8 + EXTRA); end
      release_rsp(2);
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_write[2] = 1'b1;
      req_addr[2]  = 32'h40;
      req_wdata[2] = 32'h5A5A5A5A;
      req_wmask[2] = 4'hF;
      @(posedge clk);
      #1 req_valid[2] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (rsp_valid[2] !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", rsp_valid[2]); end
      checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", req_ready[2]); end
      checks++; if (rsp_write[2] !== 1'b0) begin errors++; $display("FAIL midrst_write: got %b required 0", rsp_write[2]); end
      checks++; if (rsp_err[2] !== 1'b0 || rsp_rdata[2] !== 32'h0) begin errors++; $display("FAIL midrst_err_data: got err=%b data=%h required 0/0", rsp_err[2], rsp_rdata[2]); end
      @(negedge clk);
      rst = 1'b1;
      send(2, 1'b0, 32'h40, '0, '0, lat);
      checks++; if (rsp_rdata[2] !== 32'h12345678) begin errors++; $display("FAIL midrst_mem: got %h required 12345678", rsp_rdata[2]); end
      release_rsp(2);
   endtask

`ifdef SRAM_RAND_DELAY_EN
   task automatic run_reads(input int p);
      int lat;
      for (int i = 0; i < 64; i++) begin
         send(0, 1'b0, 32'(i * 4), '0, '0, lat);
         lat_seq[p][i] = lat;
         release_rsp(0);
      end
   endtask

   task automatic test_rand_delay();
      int distinct;
      do_reset();
      run_reads(0);
      do_reset();
      run_reads(1);
      distinct = 0;
      for (int i = 0; i < 64; i++) begin
         checks++; if (lat_seq[0][i] < 1 || lat_seq[0][i] > 8) begin errors++; $display("FAIL rand_range[%0d]: got %0d required 1..8", i, lat_seq[0][i]); end
         checks++; if (lat_seq[1][i] !== lat_seq[0][i]) begin errors++; $display("FAIL rand_replay[%0d]: got %0d required %0d", i, lat_seq[1][i], lat_seq[0][i]); end
         if (lat_seq[0][i] != lat_seq[0][0]) distinct++;
      end
      checks++; if (distinct == 0) begin errors++; $display("FAIL rand_variety: got all latencies %0d, required some variation", lat_seq[0][0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_partial_mask();
      test_latency_backpressure();
      test_out_of_range();
      test_reset_mid();
`ifdef SRAM_RAND_DELAY_EN
      test_rand_delay();
`endif
      do_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
